// File: rtl/rc_window_buffer.sv
// =============================================================================
// rc_window_buffer
// -----------------------------------------------------------------------------
// Streaming 2x2 window generator feeding the Roberts Cross edge stage.
// Pixels arrive one per handshake in row-major order over a ROWS x COLS frame.
// For every complete 2x2 neighbourhood with top-left (i,j) one window is
// emitted:
//    p00 = pix[i][j]     p01 = pix[i][j+1]
//    p10 = pix[i+1][j]   p11 = pix[i+1][j+1]
// together with i, j, a border flag (i==0 || j==0) and a last flag on the
// final window of the frame. The window is registered, appearing one cycle
// after the pixel that completes it is accepted.
//
// Optional feature (macro RC_FRAME_SYNC_EN):
//    Adds in_sof (qualified by in_valid), which forces the accepted pixel to
//    position (0,0), and the sticky flag sync_err, which records that in_sof
//    arrived while the counters were not already at (0,0).
//
// Ports:
//    clk         in   clock, rising edge
//    rst_n       in   synchronous active-low reset
//    in_valid    in   input pixel valid
//    in_ready    out  block can accept a pixel
//    in_pixel    in   pixel value [DW]
//    out_valid   out  window valid
//    out_ready   in   downstream accepts window
//    out_p00/p01/p10/p11  out  window pixels [DW]
//    out_row     out  top-left row i [RW]
//    out_col     out  top-left column j [CW]
//    out_border  out  i==0 || j==0
//    out_last    out  window (ROWS-2, COLS-2)
//    in_sof      in   start of frame (RC_FRAME_SYNC_EN only)
//    sync_err    out  sticky frame sync error (RC_FRAME_SYNC_EN only)
// =============================================================================
module rc_window_buffer #(
   parameter  int ROWS = 242,
   parameter  int COLS = 247,
   parameter  int DW   = 8,
   localparam int RW   = $clog2(ROWS),
   localparam int CW   = $clog2(COLS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_pixel,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_p00,
   output logic [DW-1:0] out_p01,
   output logic [DW-1:0] out_p10,
   output logic [DW-1:0] out_p11,
   output logic [RW-1:0] out_row,
   output logic [CW-1:0] out_col,
   output logic          out_border,
   output logic          out_last
`ifdef RC_FRAME_SYNC_EN
   ,
   input  logic          in_sof,
   output logic          sync_err
`endif
);

   localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
   localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;

   logic [DW-1:0] left_cur_q, left_cur_d;
   logic [DW-1:0] left_top_q, left_top_d;
   logic [DW-1:0] linebuf_q [COLS];

   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] p00_q, p00_d;
   logic [DW-1:0] p01_q, p01_d;
   logic [DW-1:0] p10_q, p10_d;
   logic [DW-1:0] p11_q, p11_d;
   logic [RW-1:0] out_row_q, out_row_d;
   logic [CW-1:0] out_col_q, out_col_d;
   logic          border_q, border_d;
   logic          last_q, last_d;

`ifdef RC_FRAME_SYNC_EN
   logic          sync_err_q, sync_err_d;
`endif

   // Per-pixel working signals
   logic          accept;
   logic          emit;
   logic [RW-1:0] pos_r;
   logic [CW-1:0] pos_c;
   logic [DW-1:0] top;

   // The output register can take a new window whenever it is empty or is
   // being drained this cycle, so a full stream runs at one pixel per clock.
   assign in_ready = !out_valid_q || out_ready;

   // ---------------------------------------------------------------------
   // Position, window formation and next-state
   // ---------------------------------------------------------------------
   always_comb begin
      accept = in_valid && in_ready;

      pos_r = row_q;
      pos_c = col_q;
`ifdef RC_FRAME_SYNC_EN
      // Start-of-frame overrides the counters; such a pixel is (0,0).
      if (in_sof) begin
         pos_r = '0;
         pos_c = '0;
      end
`endif

      top = linebuf_q[pos_c];

      // A window exists only once both a previous row and a previous column
      // are available. At column 0 left_cur/left_top still hold the previous
      // row's tail, which is why they are never used there.
      emit = accept && (pos_r != '0) && (pos_c != '0);

      // Counters
      row_d = row_q;
      col_d = col_q;
      if (accept) begin
         if (pos_c == C_LAST) begin
            col_d = '0;
            row_d = (pos_r == R_LAST) ? '0 : pos_r + RW'(1);
         end else begin
            col_d = pos_c + CW'(1);
            row_d = pos_r;
         end
      end

      // Neighbourhood registers
      left_cur_d = left_cur_q;
      left_top_d = left_top_q;
      if (accept) begin
         left_cur_d = in_pixel;
         left_top_d = top;
      end

      // Output register: load on a new window, clear when drained, else hold
      out_valid_d = out_valid_q;
      p00_d       = p00_q;
      p01_d       = p01_q;
      p10_d       = p10_q;
      p11_d       = p11_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      border_d    = border_q;
      last_d      = last_q;
      if (emit) begin
         out_valid_d = 1'b1;
         p00_d       = left_top_q;
         p01_d       = top;
         p10_d       = left_cur_q;
         p11_d       = in_pixel;
         out_row_d   = pos_r - RW'(1);
         out_col_d   = pos_c - CW'(1);
         border_d    = (pos_r == RW'(1)) || (pos_c == CW'(1));
         last_d      = (pos_r == R_LAST) && (pos_c == C_LAST);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

`ifdef RC_FRAME_SYNC_EN
      sync_err_d = sync_err_q;
      if (accept && in_sof && ((row_q != '0) || (col_q != '0))) begin
         sync_err_d = 1'b1;
      end
`endif
   end

   // ---------------------------------------------------------------------
   // Control and output registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_q       <= '0;
         col_q       <= '0;
         out_valid_q <= 1'b0;
         p00_q       <= '0;
         p01_q       <= '0;
         p10_q       <= '0;
         p11_q       <= '0;
         out_row_q   <= '0;
         out_col_q   <= '0;
         border_q    <= 1'b0;
         last_q      <= 1'b0;
      end else begin
         row_q       <= row_d;
         col_q       <= col_d;
         out_valid_q <= out_valid_d;
         p00_q       <= p00_d;
         p01_q       <= p01_d;
         p10_q       <= p10_d;
         p11_q       <= p11_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
         border_q    <= border_d;
         last_q      <= last_d;
      end
   end

`ifdef RC_FRAME_SYNC_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_err_q <= 1'b0;
      end else begin
         sync_err_q <= sync_err_d;
      end
   end
   assign sync_err = sync_err_q;
`endif

   // ---------------------------------------------------------------------
   // Data storage (no reset: row 0 of every frame rewrites the line buffer
   // before any of it is read, and left_* are ignored at column 0)
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      left_cur_q <= left_cur_d;
      left_top_q <= left_top_d;
      if (rst_n && accept) begin
         linebuf_q[pos_c] <= in_pixel;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_p00    = p00_q;
   assign out_p01    = p01_q;
   assign out_p10    = p10_q;
   assign out_p11    = p11_q;
   assign out_row    = out_row_q;
   assign out_col    = out_col_q;
   assign out_border = border_q;
   assign out_last   = last_q;

endmodule
